// File: rtl/cmp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  cmp_pkg : shared types and defaults for the shared-comparator arbiter
//  Revision: 1.0
// ---------------------------------------------------------------------------
package cmp_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_NREQ  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      RESP    = 2'd2
   } state_t;

   typedef struct packed {
      logic eq;
      logic gt;
      logic lt;
   } cmp_res_t;

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/comparator_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  comparator_core : combinational unsigned magnitude comparator
//  Revision: 1.0
// ---------------------------------------------------------------------------
module comparator_core
   import cmp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output cmp_res_t         res_o
);

   always_comb begin
      res_o.eq = (a_i == b_i);
      res_o.gt = (a_i >  b_i);
      res_o.lt = (a_i <  b_i);
   end

endmodule : comparator_core
`default_nettype wire

// File: rtl/cmp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
//  cmp_arbiter : round-robin sharing of one comparator among NREQ requesters
//  Revision: 1.0
// ---------------------------------------------------------------------------
module cmp_arbiter
   import cmp_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic                  rsp_eq,
   output logic                  rsp_gt,
   output logic                  rsp_lt,
   input  logic                  rsp_ready,
   output logic                  busy
);

   state_t           state_q;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   ptr_d;
   logic [IDW-1:0]   win;
   logic             found;
   logic [WIDTH-1:0] mux_a;
   logic [WIDTH-1:0] mux_b;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IDW-1:0]   id_q;
   cmp_res_t         res;
   cmp_res_t         rsp_res_q;
   logic             rsp_valid_q;
   logic [IDW-1:0]   rsp_id_q;
   logic             busy_q;

   // First valid requester scanning upward from ptr, wrapping at NREQ.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   assign ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
   assign mux_a = req_a[win*WIDTH +: WIDTH];
   assign mux_b = req_b[win*WIDTH +: WIDTH];

   // Gated by rst_n so no grant is visible while reset is held.
   always_comb begin
      req_ready = '0;
      if (rst_n && (state_q == IDLE) && found) begin
         req_ready[win] = 1'b1;
      end
   end

   comparator_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a_i   (a_q),
      .b_i   (b_q),
      .res_o (res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_res_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  a_q     <= mux_a;
                  b_q     <= mux_b;
                  id_q    <= win;
                  ptr_q   <= ptr_d;
                  busy_q  <= 1'b1;
                  state_q <= COMPARE;
               end
            end
            COMPARE: begin
               rsp_res_q   <= res;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_eq    = rsp_res_q.eq;
   assign rsp_gt    = rsp_res_q.gt;
   assign rsp_lt    = rsp_res_q.lt;
   assign busy      = busy_q;

endmodule : cmp_arbiter
`default_nettype wire
